// File: rtl/typedef_pkg.sv
// Shared rename/ROB types: physical register IDs, free-list sizing and the ROB entry layout.
package typedef_pkg;

  localparam int NUM_PHY_REGS  = 64;
  localparam int PHY_WIDTH     = 6;
  localparam int NUM_ARCH_REGS = 32;
  localparam int ARCH_WIDTH    = 5;
  localparam int FREE_DEPTH    = NUM_PHY_REGS - NUM_ARCH_REGS;
  localparam int FREE_PTR_W    = $clog2(FREE_DEPTH);
  localparam int FREE_CNT_W    = FREE_PTR_W + 1;

  typedef logic [PHY_WIDTH-1:0]  phy_reg_t;
  typedef logic [ARCH_WIDTH-1:0] arch_reg_t;
  typedef logic [FREE_PTR_W-1:0] free_ptr_t;
  typedef logic [FREE_CNT_W-1:0] free_cnt_t;

  typedef struct packed {
    logic      valid;
    logic      done;
    logic      rd_valid;
    arch_reg_t rd_arch;
    phy_reg_t  rd_phy;
    phy_reg_t  rd_phy_old;
  } ROB_ENTRY_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {v[1] & v[0], v[1] ^ v[0]};
  endfunction

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register IDs: two allocations per cycle, one in-order release,
// and single-cycle flush recovery through a committed head pointer.
module phys_reg_free_list
  import typedef_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic [1:0] alloc_valid,
  output phy_reg_t  alloc_phy_0,
  output phy_reg_t  alloc_phy_1,
  output logic      free_stall,
  output free_cnt_t free_count,
  input  logic      retire_pr_valid,
  input  arch_reg_t rd_arch_commit,
  input  phy_reg_t  rd_phy_old_commit,
  output logic      alloc_error
);

  phy_reg_t  list_q [FREE_DEPTH];
  free_ptr_t head_q, head_d;
  free_ptr_t commit_head_q, commit_head_d;
  free_ptr_t tail_q, tail_d;
  free_cnt_t count_q, count_d;
  logic      alloc_error_q, alloc_error_d;

  free_ptr_t head_p1;
  free_cnt_t n_alloc;
  logic      grant;
  logic      do_release;

  assign head_p1    = head_q + free_ptr_t'(1);
  assign free_stall = (count_q < free_cnt_t'(2));
  assign free_count = count_q;
  assign alloc_error = alloc_error_q;

  // A lone slot-1 request takes the head entry, otherwise slot 1 sees head+1.
  assign alloc_phy_0 = list_q[head_q];
  assign alloc_phy_1 = (alloc_valid == 2'b10) ? list_q[head_q] : list_q[head_p1];

  assign grant      = !free_stall && !flush;
  assign n_alloc    = grant ? free_cnt_t'(popcount2(alloc_valid)) : '0;
  // x0 never owned a renamed register, so its retirement returns nothing.
  assign do_release = retire_pr_valid && (rd_arch_commit != '0) && !flush;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    head_d        = head_q;
    commit_head_d = commit_head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    alloc_error_d = alloc_error_q | ((|alloc_valid) & free_stall);
    if (flush) begin
      head_d  = commit_head_q;
      count_d = free_cnt_t'(FREE_DEPTH);
    end else begin
      head_d  = head_q + n_alloc[FREE_PTR_W-1:0];
      count_d = count_q - n_alloc + free_cnt_t'(do_release);
      if (do_release) begin
        tail_d        = tail_q + free_ptr_t'(1);
        commit_head_d = commit_head_q + free_ptr_t'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= '0;
      count_q       <= free_cnt_t'(FREE_DEPTH);
      alloc_error_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      alloc_error_q <= alloc_error_d;
    end
  end

  // NOTE: the list storage is reset on purpose: its contents after reset are the initial free PRs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FREE_DEPTH; i++) begin
        list_q[i] <= phy_reg_t'(NUM_ARCH_REGS + i);
      end
    end else if (do_release) begin
      list_q[tail_q] <= rd_phy_old_commit;
    end
  end

  // Releasing into a full list would overwrite a free entry.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_release && (count_q == free_cnt_t'(FREE_DEPTH))));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: queue-based reference model plus hand-computed pins.
module tb_phys_reg_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] alloc_valid;
  logic [5:0] alloc_phy_0, alloc_phy_1;
  logic       free_stall;
  logic [5:0] free_count;
  logic       retire_pr_valid;
  logic [4:0] rd_arch_commit;
  logic [5:0] rd_phy_old_commit;
  logic       alloc_error;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: the ring is "in-flight (allocated, uncommitted)" followed by "free".
  int m_free[$];
  int m_inflight[$];
  bit m_err;
  bit m_stall;
  bit m_rel;

  phys_reg_free_list dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .alloc_valid      (alloc_valid),
    .alloc_phy_0      (alloc_phy_0),
    .alloc_phy_1      (alloc_phy_1),
    .free_stall       (free_stall),
    .free_count       (free_count),
    .retire_pr_valid  (retire_pr_valid),
    .rd_arch_commit   (rd_arch_commit),
    .rd_phy_old_commit(rd_phy_old_commit),
    .alloc_error      (alloc_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_free.delete();
    m_inflight.delete();
    for (int i = 0; i < 32; i++) m_free.push_back(32 + i);
    m_err = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_stall = (m_free.size() < 2);
      if (alloc_valid != 2'b00 && m_stall) m_err = 1'b1;
      if (flush) begin
        m_free = {m_inflight, m_free};
        m_inflight.delete();
      end else begin
        m_rel = retire_pr_valid && (rd_arch_commit != 5'd0);
        if (m_rel) void'(m_inflight.pop_front());
        if (!m_stall) begin
          if (alloc_valid[0]) m_inflight.push_back(m_free.pop_front());
          if (alloc_valid[1]) m_inflight.push_back(m_free.pop_front());
        end
        if (m_rel) m_free.push_back(int'(rd_phy_old_commit));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_count", free_count, m_free.size());
      check("model_stall", free_stall, (m_free.size() < 2) ? 1 : 0);
      check("model_error", alloc_error, m_err);
      if (m_free.size() >= 2) begin
        check("model_phy0", alloc_phy_0, m_free[0]);
        check("model_phy1", alloc_phy_1, (alloc_valid == 2'b10) ? m_free[0] : m_free[1]);
      end
    end
  end

  task automatic drive(input logic [1:0] av, input logic rv, input int rd, input int old,
                       input logic fl);
    alloc_valid       = av;
    retire_pr_valid   = rv;
    rd_arch_commit    = 5'(rd);
    rd_phy_old_commit = 6'(old);
    flush             = fl;
  endtask

  task automatic edge_idle();
    @(posedge clk);
    #1;
    drive(2'b00, 1'b0, 0, 0, 1'b0);
    #1;
  endtask

  task automatic tick(input logic [1:0] av, input logic rv, input int rd, input int old,
                      input logic fl);
    drive(av, rv, rd, old, fl);
    edge_idle();
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  logic [1:0] pat [6] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b11, 2'b11};

  initial begin
    drive(2'b00, 1'b0, 0, 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_count", free_count, 32);
    check("rst_stall", free_stall, 0);
    check("rst_error", alloc_error, 0);
    check("rst_phy0", alloc_phy_0, 32);
    check("rst_phy1", alloc_phy_1, 33);

    // Pair allocation, then head advanced by two.
    drive(2'b11, 1'b0, 0, 0, 1'b0);
    #1;
    check("pair_phy0", alloc_phy_0, 32);
    check("pair_phy1", alloc_phy_1, 33);
    edge_idle();
    check("pair_count", free_count, 30);
    check("pair_head2", alloc_phy_0, 34);

    // Lone slot-1 request takes the head entry.
    do_reset();
    drive(2'b10, 1'b0, 0, 0, 1'b0);
    #1;
    check("slot1_phy1", alloc_phy_1, 32);
    edge_idle();
    check("slot1_count", free_count, 31);
    drive(2'b11, 1'b0, 0, 0, 1'b0);
    #1;
    check("slot1_next0", alloc_phy_0, 33);
    check("slot1_next1", alloc_phy_1, 34);
    edge_idle();

    // Drain to empty, then a stalled request is dropped and flagged.
    do_reset();
    repeat (15) tick(2'b11, 1'b0, 0, 0, 1'b0);
    check("drain_count2", free_count, 2);
    check("drain_stall0", free_stall, 0);
    drive(2'b11, 1'b0, 0, 0, 1'b0);
    #1;
    check("last_phy0", alloc_phy_0, 62);
    check("last_phy1", alloc_phy_1, 63);
    edge_idle();
    check("empty_count", free_count, 0);
    check("empty_stall", free_stall, 1);
    check("empty_err0", alloc_error, 0);
    tick(2'b01, 1'b0, 0, 0, 1'b0);
    check("drop_err", alloc_error, 1);
    check("drop_count", free_count, 0);
    check("drop_head", alloc_phy_0, 32);

    // Release and allocate in the same cycle; PR5 only comes back after the wrap.
    do_reset();
    tick(2'b11, 1'b0, 0, 0, 1'b0);
    drive(2'b01, 1'b1, 5, 5, 1'b0);
    #1;
    check("relalloc_phy0", alloc_phy_0, 34);
    edge_idle();
    check("relalloc_count", free_count, 30);
    repeat (14) tick(2'b11, 1'b0, 0, 0, 1'b0);
    drive(2'b11, 1'b0, 0, 0, 1'b0);
    #1;
    check("wrap_phy0", alloc_phy_0, 63);
    check("wrap_phy1", alloc_phy_1, 5);
    edge_idle();
    check("wrap_count", free_count, 0);

    // Flush restores head to the committed head.
    do_reset();
    tick(2'b11, 1'b0, 0, 0, 1'b0);
    tick(2'b11, 1'b0, 0, 0, 1'b0);
    tick(2'b00, 1'b1, 3, 3, 1'b0);
    check("pre_flush_count", free_count, 29);
    tick(2'b00, 1'b0, 0, 0, 1'b1);
    check("flush_count", free_count, 32);
    drive(2'b11, 1'b0, 0, 0, 1'b0);
    #1;
    check("flush_phy0", alloc_phy_0, 33);
    check("flush_phy1", alloc_phy_1, 34);
    edge_idle();

    // Flush wins over a same-cycle retire; x0 retire frees nothing.
    tick(2'b00, 1'b1, 7, 7, 1'b1);
    check("flushret_count", free_count, 32);
    drive(2'b11, 1'b0, 0, 0, 1'b0);
    #1;
    check("flushret_phy0", alloc_phy_0, 33);
    check("flushret_phy1", alloc_phy_1, 34);
    edge_idle();
    tick(2'b00, 1'b1, 0, 9, 1'b0);
    check("x0_count", free_count, 30);

    // Mixed directed traffic checked by the model every cycle.
    for (int i = 0; i < 60; i++) begin
      tick(pat[i % 6], (i % 3 == 0) && (m_inflight.size() > 0), i % 8, 32 + (i * 5) % 32,
           (i == 37) || (i == 51));
    end

    // Asynchronous reset mid-cycle.
    tick(2'b11, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_count", free_count, 32);
    check("async_stall", free_stall, 0);
    check("async_err", alloc_error, 0);
    check("async_phy0", alloc_phy_0, 32);
    check("async_phy1", alloc_phy_1, 33);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2'b00, 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
